// File: rtl/temp_sampler_pkg.sv
// rtl/temp_sampler_pkg.sv - shared constants and FSM encoding for temp_sampler
package temp_sampler_pkg;

   localparam int C_SAMPLE_W = 10;

   localparam logic signed [C_SAMPLE_W-1:0] C_RANGE_MIN = -10'sd40;
   localparam logic signed [C_SAMPLE_W-1:0] C_RANGE_MAX = 10'sd200;

   localparam int C_DEF_PERIOD   = 10;
   localparam int C_DEF_TIMEOUT  = 40;
   localparam int C_DEF_AVG_LOG2 = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_UPDATE  = 2'd3
   } state_t;

endpackage

// File: rtl/temp_avg_window.sv
// rtl/temp_avg_window.sv - circular moving-average window with running sum
// The average register is updated in the same clock as the load.
module temp_avg_window
   import temp_sampler_pkg::*;
#(
   parameter int g_avg_log2 = C_DEF_AVG_LOG2
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_load,
   input  logic                  i_prefill,
   input  logic [C_SAMPLE_W-1:0] i_sample,
   output logic [C_SAMPLE_W-1:0] o_avg
);

   localparam int C_DEPTH = 1 << g_avg_log2;
   localparam int C_SUM_W = C_SAMPLE_W + g_avg_log2;
   localparam int C_PTR_W = (g_avg_log2 > 0) ? g_avg_log2 : 1;

   logic [C_SAMPLE_W-1:0]     r_buf [C_DEPTH];
   logic [C_PTR_W-1:0]        r_wptr;
   logic signed [C_SUM_W-1:0] r_sum;
   logic [C_SAMPLE_W-1:0]     r_avg;

   logic signed [C_SUM_W-1:0] w_new;
   logic signed [C_SUM_W-1:0] w_oldest;
   logic signed [C_SUM_W-1:0] w_sum_next;
   logic [C_PTR_W-1:0]        w_wptr_next;

   assign w_new    = C_SUM_W'($signed(i_sample));
   assign w_oldest = C_SUM_W'($signed(r_buf[r_wptr]));

   // Prefill makes every slot equal to the first sample, so the sum is a plain shift.
   assign w_sum_next  = i_prefill ? (w_new <<< g_avg_log2) : (r_sum + w_new - w_oldest);
   assign w_wptr_next = (r_wptr == C_PTR_W'(C_DEPTH - 1)) ? '0 : r_wptr + 1'b1;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < C_DEPTH; i++) begin
            r_buf[i] <= '0;
         end
         r_wptr <= '0;
         r_sum  <= '0;
         r_avg  <= '0;
      end else if (i_load) begin
         if (i_prefill) begin
            for (int i = 0; i < C_DEPTH; i++) begin
               r_buf[i] <= i_sample;
            end
         end else begin
            r_buf[r_wptr] <= i_sample;
         end
         r_wptr <= w_wptr_next;
         r_sum  <= w_sum_next;
         r_avg  <= C_SAMPLE_W'(w_sum_next >>> g_avg_log2);
      end
   end

   assign o_avg = r_avg;

endmodule

// File: rtl/temp_sampler.sv
// rtl/temp_sampler.sv - periodic SPI temperature request, capture and averaging
// Optional macro SAMPLE_RANGE_CHECK_EN rejects samples outside -10.0 C..50.0 C.
module temp_sampler
   import temp_sampler_pkg::*;
#(
   parameter int g_sample_period = C_DEF_PERIOD,
   parameter int g_timeout       = C_DEF_TIMEOUT,
   parameter int g_avg_log2      = C_DEF_AVG_LOG2
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_enable,
   output logic                  o_read_therm,
   input  logic                  i_therm_ready,
   input  logic [C_SAMPLE_W-1:0] i_spi_temperature,
   output logic [C_SAMPLE_W-1:0] o_temperature,
   output logic                  o_temp_valid,
   output logic                  o_sample_stb,
   output logic                  o_therm_fault
);

   localparam int C_PER_W = $clog2(g_sample_period);
   localparam int C_TO_W  = $clog2(g_timeout + 1);

   state_t                r_state;
   logic [C_PER_W-1:0]    r_period_cnt;
   logic [C_TO_W-1:0]     r_timeout_cnt;
   logic                  r_read_therm;
   logic [C_SAMPLE_W-1:0] r_sample;
   logic                  r_temp_valid;
   logic                  r_sample_stb;
   logic                  r_therm_fault;

   logic                  w_load;
   logic [C_SAMPLE_W-1:0] w_avg;

`ifdef SAMPLE_RANGE_CHECK_EN
   logic w_in_range;
   assign w_in_range = ($signed(i_spi_temperature) >= C_RANGE_MIN) &&
                       ($signed(i_spi_temperature) <= C_RANGE_MAX);
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_period_cnt  <= '0;
         r_timeout_cnt <= '0;
         r_read_therm  <= 1'b0;
         r_sample      <= '0;
         r_temp_valid  <= 1'b0;
         r_sample_stb  <= 1'b0;
         r_therm_fault <= 1'b0;
      end else begin
         r_sample_stb <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!i_enable) begin
                  r_period_cnt <= '0;
               end else if (r_period_cnt == C_PER_W'(g_sample_period - 1)) begin
                  // A stale ready from the previous read holds us at terminal count.
                  if (!i_therm_ready) begin
                     r_state       <= ST_REQ;
                     r_read_therm  <= 1'b1;
                     r_timeout_cnt <= '0;
                  end
               end else begin
                  r_period_cnt <= r_period_cnt + 1'b1;
               end
            end
            ST_REQ: begin
               if (i_therm_ready) begin
                  r_state      <= ST_CAPTURE;
                  r_read_therm <= 1'b0;
               end else if (r_timeout_cnt == C_TO_W'(g_timeout - 1)) begin
                  r_state       <= ST_IDLE;
                  r_read_therm  <= 1'b0;
                  r_therm_fault <= 1'b1;
                  r_period_cnt  <= '0;
               end else begin
                  r_timeout_cnt <= r_timeout_cnt + 1'b1;
               end
            end
            ST_CAPTURE: begin
               r_sample <= i_spi_temperature;
`ifdef SAMPLE_RANGE_CHECK_EN
               if (w_in_range) begin
                  r_state <= ST_UPDATE;
               end else begin
                  r_state       <= ST_IDLE;
                  r_therm_fault <= 1'b1;
                  r_period_cnt  <= '0;
               end
`else
               r_state <= ST_UPDATE;
`endif
            end
            ST_UPDATE: begin
               r_state       <= ST_IDLE;
               r_sample_stb  <= 1'b1;
               r_temp_valid  <= 1'b1;
               r_therm_fault <= 1'b0;
               r_period_cnt  <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_load = (r_state == ST_UPDATE);

   temp_avg_window #(
      .g_avg_log2 (g_avg_log2)
   ) u_window (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_load),
      .i_prefill (!r_temp_valid),
      .i_sample  (r_sample),
      .o_avg     (w_avg)
   );

   assign o_read_therm  = r_read_therm;
   assign o_temperature = w_avg;
   assign o_temp_valid  = r_temp_valid;
   assign o_sample_stb  = r_sample_stb;
   assign o_therm_fault = r_therm_fault;

endmodule

// File: tb/tb_temp_sampler.sv
// tb/tb_temp_sampler.sv - scoreboard bench for temp_sampler with a queue-based averaging model
module tb_temp_sampler;

   localparam int P  = 10;
   localparam int TO = 40;
   localparam int L  = 2;
   localparam int D  = 1 << L;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       ready = 1'b0;
   logic [9:0] spi = '0;
   logic       o_read_therm;
   logic [9:0] o_temperature;
   logic       o_temp_valid;
   logic       o_sample_stb;
   logic       o_therm_fault;

   always #5 clk = ~clk;

   temp_sampler #(
      .g_sample_period (P),
      .g_timeout       (TO),
      .g_avg_log2      (L)
   ) dut (
      .i_clk             (clk),
      .i_reset_n         (rst_n),
      .i_enable          (en),
      .o_read_therm      (o_read_therm),
      .i_therm_ready     (ready),
      .i_spi_temperature (spi),
      .o_temperature     (o_temperature),
      .o_temp_valid      (o_temp_valid),
      .o_sample_stb      (o_sample_stb),
      .o_therm_fault     (o_therm_fault)
   );

   int         errors = 0;
   int         checks = 0;
   logic [9:0] exp_q[$];
   int         hist[$];
   logic [9:0] cur_exp = '0;
   logic [9:0] mon_exp;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int floor_div(input int s, input int d);
      int r;
      r = s % d;
      if (r < 0) r += d;
      return (s - r) / d;
   endfunction

   // Reference: window of the last D accepted samples, mean rounded toward -inf.
   task automatic model_sample(input logic [9:0] v, output bit acc);
      int sv;
      int sum;
      sv  = int'($signed(v));
      acc = 1'b1;
`ifdef SAMPLE_RANGE_CHECK_EN
      if (sv < -40 || sv > 200) acc = 1'b0;
`endif
      if (acc) begin
         if (hist.size() == 0) begin
            for (int i = 0; i < D; i++) hist.push_back(sv);
         end else begin
            hist.push_back(sv);
            void'(hist.pop_front());
         end
         sum = 0;
         foreach (hist[i]) sum += hist[i];
         cur_exp = 10'(floor_div(sum, D));
         exp_q.push_back(cur_exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && o_sample_stb) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got strobe with temperature 0x%0h, expected none at %0t", o_temperature, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_temperature", int'(o_temperature), int'(mon_exp));
            check("sb_valid", int'(o_temp_valid), 1);
         end
      end
   end

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (o_read_therm) begin
            ok = 1'b1;
            break;
         end
      end
      check("req_seen", int'(ok), 1);
   endtask

   task automatic respond(input logic [9:0] v, input int delay);
      bit acc;
      for (int i = 0; i < delay; i++) begin
         @(posedge clk);
         #1;
      end
      ready = 1'b1;
      spi   = v;
      model_sample(v, acc);
      @(posedge clk);
      #1;
      check("req_drop", int'(o_read_therm), 0);
      @(posedge clk);
      #1;
      ready = 1'b0;
      @(posedge clk);
      #1;
      check("stb_latency", int'(o_sample_stb), int'(acc));
      check("fault_after_read", int'(o_therm_fault), int'(!acc));
      check("temp_after_read", int'(o_temperature), int'(cur_exp));
   endtask

   task automatic read(input logic [9:0] v, input int delay);
      bit ok;
      wait_req(ok);
      if (ok) respond(v, delay);
   endtask

   task automatic no_req_window(input string name, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (o_read_therm) seen = 1'b1;
      end
      check(name, int'(seen), 0);
   endtask

   logic [9:0] seq_in  [4] = '{10'h068, 10'h068, 10'h06C, 10'h06C};
   logic [9:0] seq_out [4] = '{10'h065, 10'h066, 10'h068, 10'h06A};

   initial begin
      int cnt;
      bit ok;
      en = 1'b1;
      #12;
      check("rst_read_therm", int'(o_read_therm), 0);
      check("rst_temperature", int'(o_temperature), 0);
      check("rst_valid", int'(o_temp_valid), 0);
      check("rst_stb", int'(o_sample_stb), 0);
      check("rst_fault", int'(o_therm_fault), 0);
      #18 rst_n = 1'b1;

      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cnt++;
         if (o_read_therm) break;
      end
      check("first_req_clocks", cnt, P);
      respond(10'h064, 3);
      check("first_temp", int'(o_temperature), 'h064);
      check("first_valid", int'(o_temp_valid), 1);

      for (int k = 0; k < 4; k++) begin
         read(seq_in[k], 1 + k);
         check("seq_avg", int'(o_temperature), int'(seq_out[k]));
      end

      wait_req(ok);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cnt++;
         if (!o_read_therm) break;
      end
      check("timeout_clocks", cnt, TO);
      check("timeout_fault", int'(o_therm_fault), 1);
      check("timeout_temp_held", int'(o_temperature), 'h06A);
      read(10'h070, 2);
      check("fault_cleared", int'(o_therm_fault), 0);

      read(10'h0CC, 2);

      en = 1'b0;
      no_req_window("no_req_disabled", 40);

      en = 1'b1;
      wait_req(ok);
      en = 1'b0;
      if (ok) respond(10'h050, 1);
      no_req_window("no_req_after_drop", 40);

      en = 1'b1;
      wait_req(ok);
      #3 rst_n = 1'b0;
      #1;
      check("midreq_read_therm", int'(o_read_therm), 0);
      check("midreq_valid", int'(o_temp_valid), 0);
      check("midreq_temp", int'(o_temperature), 0);
      hist.delete();
      exp_q.delete();
      cur_exp = '0;
      ready = 1'b0;
      #2 rst_n = 1'b1;

      read(10'h3FC, 1);
      read(10'h3FD, 2);
      check("floor_round", int'(o_temperature), 'h3FC);

      for (int k = 0; k < 20; k++) begin
         read(10'($urandom), int'($urandom_range(0, 6)));
      end

      repeat (5) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
